// File: rtl/operand_fetch.sv
// RV32I operand fetch: decodes, reads/bypasses operands and registers them for EX; 1-cycle latency.
// Holds one instruction; in_ready drops on output backpressure, load-use hazard, flush or reset.
module operand_fetch #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic [4:0]      ReadRegister1,
    output logic [4:0]      ReadRegister2,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            hz_busy,
    input  logic [4:0]      hz_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            illegal;
    logic            stall;
    logic            xfer_in;
    logic [31:0]     imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign opcode        = in_instr[6:0];
    assign rs1           = in_instr[19:15];
    assign rs2           = in_instr[24:20];
    assign ReadRegister1 = rs1;
    assign ReadRegister2 = rs2;

    always_comb begin
        uses_rs1 = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
        uses_rs2 = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
        illegal  = 1'b0;
        imm      = '0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM:
                imm = {{20{in_instr[31]}}, in_instr[31:20]};
            OPC_STORE:
                imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OPC_BRANCH:
                imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {in_instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
            OPC_OP:
                imm = '0;
            default:
                illegal = 1'b1;
        endcase
    end

    // The register file only commits at the edge, so a same-cycle writeback must be forwarded.
    function automatic logic [XLEN-1:0] sel_operand(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_val,
        input logic            wen,
        input logic [4:0]      wrd,
        input logic [XLEN-1:0] wdat
    );
        if (rs == 5'd0)
            return '0;
        else if (wen && wrd == rs)
            return wdat;
        else
            return rf_val;
    endfunction

    assign rs1_val = sel_operand(rs1, ReadData1, wb_en, wb_rd, wb_data);
    assign rs2_val = sel_operand(rs2, ReadData2, wb_en, wb_rd, wb_data);

    assign stall = in_valid && hz_busy && (hz_rd != 5'd0) &&
                   ((uses_rs1 && hz_rd == rs1) || (uses_rs2 && hz_rd == rs2));

    assign in_ready = rst && (!out_valid || out_ready) && !stall && !flush;
    assign xfer_in  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_val  <= '0;
            out_rs2_val  <= '0;
            out_imm      <= '0;
            out_rd       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (xfer_in) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs1_val  <= rs1_val;
            out_rs2_val  <= rs2_val;
            out_imm      <= imm;
            out_rd       <= in_instr[11:7];
            out_opcode   <= opcode;
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
            out_illegal  <= illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed-vector bench for operand_fetch with hand-computed expectations.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hz_busy;
    logic [4:0]  hz_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    operand_fetch #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .hz_busy      (hz_busy),
        .hz_rd        (hz_rd),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h100;
        ReadData1 = 32'h1234; ReadData2 = 32'h0; wb_en = 1'b0; wb_rd = 5'd0;
        wb_data = 32'h0; hz_busy = 1'b0; hz_rd = 5'd0; flush = 1'b0; out_ready = 1'b1;

        // Reset held across edges with work offered
        step(); step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
        check("rst_out_rd", {27'b0, out_rd}, 32'd0);

        // ADDI x5,x0,-1 at 0x100
        rst = 1'b1;
        #1;
        check("addi_in_ready", {31'b0, in_ready}, 32'd1);
        check("addi_rr1", {27'b0, ReadRegister1}, 32'd0);
        check("addi_rr2", {27'b0, ReadRegister2}, 32'd31);
        step();
        check("addi_valid", {31'b0, out_valid}, 32'd1);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_rs1", out_rs1_val, 32'd0);
        check("addi_rd", {27'b0, out_rd}, 32'd5);
        check("addi_pc", out_pc, 32'h100);
        check("addi_opcode", {25'b0, out_opcode}, 32'h13);

        // ADD x3,x1,x2 with writeback bypass on x2
        in_instr = 32'h002081B3; in_pc = 32'h104; ReadData1 = 32'd7; ReadData2 = 32'h99;
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
        #1;
        check("add_in_ready", {31'b0, in_ready}, 32'd1);
        check("add_rr1", {27'b0, ReadRegister1}, 32'd1);
        check("add_rr2", {27'b0, ReadRegister2}, 32'd2);
        step();
        check("add_rs1", out_rs1_val, 32'd7);
        check("add_rs2", out_rs2_val, 32'h55);
        check("add_rd", {27'b0, out_rd}, 32'd3);
        check("add_imm", out_imm, 32'd0);
        check("add_pc", out_pc, 32'h104);

        // SUB x4,x1,x2 with bypass on x1
        in_instr = 32'h40208233; in_pc = 32'h108; wb_rd = 5'd1; wb_data = 32'hAA;
        step();
        check("sub_rs1", out_rs1_val, 32'hAA);
        check("sub_rs2", out_rs2_val, 32'h99);
        check("sub_f7b5", {31'b0, out_funct7b5}, 32'd1);
        check("sub_rd", {27'b0, out_rd}, 32'd4);

        // SW x1,8(x2) stalled by a pending load to x1
        in_instr = 32'h00112423; in_pc = 32'h110; wb_en = 1'b0;
        ReadData1 = 32'h1000; ReadData2 = 32'h2222; hz_busy = 1'b1; hz_rd = 5'd1;
        #1;
        check("sw_stall_rdy0", {31'b0, in_ready}, 32'd0);
        step();
        check("sw_drain_valid", {31'b0, out_valid}, 32'd0);
        check("sw_stall_rdy1", {31'b0, in_ready}, 32'd0);
        step();
        check("sw_stall_rdy2", {31'b0, in_ready}, 32'd0);
        check("sw_stall_valid", {31'b0, out_valid}, 32'd0);
        hz_busy = 1'b0;
        #1;
        check("sw_release_rdy", {31'b0, in_ready}, 32'd1);
        step();
        check("sw_valid", {31'b0, out_valid}, 32'd1);
        check("sw_imm", out_imm, 32'd8);
        check("sw_rs1", out_rs1_val, 32'h1000);
        check("sw_rs2", out_rs2_val, 32'h2222);
        check("sw_funct3", {29'b0, out_funct3}, 32'd2);
        check("sw_pc", out_pc, 32'h110);

        // LUI x7,0x12345: rs1 field equals hz_rd but is unused, so no stall
        in_instr = 32'h123453B7; in_pc = 32'h114; hz_busy = 1'b1; hz_rd = 5'd8;
        #1;
        check("lui_rdy", {31'b0, in_ready}, 32'd1);
        step();
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_rd", {27'b0, out_rd}, 32'd7);
        hz_busy = 1'b0;

        // BEQ x1,x2,-4 held off by output backpressure for 3 cycles
        out_ready = 1'b0; in_instr = 32'hFE208EE3; in_pc = 32'h118;
        ReadData1 = 32'h11; ReadData2 = 32'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rdy", {31'b0, in_ready}, 32'd0);
            step();
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_imm", out_imm, 32'h12345000);
            check("bp_hold_pc", out_pc, 32'h114);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {31'b0, in_ready}, 32'd1);
        step();
        check("beq_imm", out_imm, 32'hFFFFFFFC);
        check("beq_opcode", {25'b0, out_opcode}, 32'h63);
        check("beq_rs1", out_rs1_val, 32'h11);
        check("beq_rs2", out_rs2_val, 32'h22);

        // JAL x0,-8
        in_instr = 32'hFF9FF06F; in_pc = 32'h11C;
        step();
        check("jal_imm", out_imm, 32'hFFFFFFF8);
        check("jal_rd", {27'b0, out_rd}, 32'd0);

        // AUIPC x10,1
        in_instr = 32'h00001517; in_pc = 32'h120;
        step();
        check("auipc_imm", out_imm, 32'h00001000);
        check("auipc_rd", {27'b0, out_rd}, 32'd10);

        // Unknown opcode still transfers, flagged illegal
        in_instr = 32'hFFFFFFFF; in_pc = 32'h124;
        step();
        check("ill_valid", {31'b0, out_valid}, 32'd1);
        check("ill_flag", {31'b0, out_illegal}, 32'd1);
        check("ill_imm", out_imm, 32'd0);

        // Flush drops both the held and the presented instruction
        in_instr = 32'h00500313; in_pc = 32'h128; flush = 1'b1; out_ready = 1'b0;
        #1;
        check("flush_rdy", {31'b0, in_ready}, 32'd0);
        step();
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("flush_valid_after", {31'b0, out_valid}, 32'd0);
        check("flush_not_seen", {31'b0, (out_rd == 5'd6)}, 32'd0);

        // Asynchronous reset between edges while holding an instruction
        in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h200; out_ready = 1'b0;
        step();
        check("mid_valid", {31'b0, out_valid}, 32'd1);
        check("mid_pc", out_pc, 32'h200);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async_valid", {31'b0, out_valid}, 32'd0);
        check("async_pc", out_pc, 32'd0);
        check("async_imm", out_imm, 32'd0);
        check("async_rdy", {31'b0, in_ready}, 32'd0);
        step();
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300;
        out_ready = 1'b1; ReadData1 = 32'd7; ReadData2 = 32'd9;
        step();
        check("post_rst_valid", {31'b0, out_valid}, 32'd1);
        check("post_rst_pc", out_pc, 32'h300);
        check("post_rst_rs2", out_rs2_val, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
